sqrt_share_arbiter: RTL and testbench
=====================================

Name: sqrt_share_arbiter

Overview:
- Shares one sqrt_non_restoring instance between NUM_REQ layernorm lanes, each needing 1/sqrt(var) style roots.
- Round-robin arbitration with one operation outstanding at a time.
- Drives the sqrt unit's valid_in/radicand_in and captures sqrt_out on valid_out.
- Returns each result to its owner lane over a valid/ready response channel, with a watchdog timeout.

Parameters:
- NUM_REQ, 4, number of requesting lanes.
- DATA_IN_WIDTH, 24, radicand width; matches sqrt unit.
- FINAL_OUT_WIDTH, 24, result width; matches sqrt unit.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before abort.
- CNT_WIDTH, 7, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1, single clock; rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-lane request valid.
- req_ready, output, NUM_REQ, per-lane accept; one-hot or zero.
- req_radicand, input, NUM_REQ*DATA_IN_WIDTH, lane i in bits [i*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- resp_valid, output, NUM_REQ, one-hot result valid to owner lane.
- resp_ready, input, NUM_REQ, per-lane result accept.
- resp_data, output, FINAL_OUT_WIDTH, shared result bus.
- resp_err, output, 1, result aborted by timeout; qualified by resp_valid.
- sqrt_valid_in, output, 1, to sqrt unit valid_in.
- sqrt_radicand, output, DATA_IN_WIDTH, to sqrt unit radicand_in.
- sqrt_valid_out, input, 1, from sqrt unit valid_out.
- sqrt_result, input, FINAL_OUT_WIDTH, from sqrt unit sqrt_out.
- busy, output, 1, high in any state other than IDLE.
- spurious_flag, output, 1, sticky: sqrt_valid_out seen outside WAIT.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; rr_ptr=0; owner=0; watchdog=0.
  - All outputs 0: req_ready, resp_valid, resp_data, resp_err, sqrt_valid_in, sqrt_radicand, busy, spurious_flag.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first lane with req_valid set, searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; no other lane is ready.
  - On that edge: latch radicand, owner=g, go to ISSUE.
  - No req_valid means stay in IDLE with req_ready=0.
- ISSUE:
  - sqrt_valid_in=1 for exactly one cycle; sqrt_radicand holds the latched value and stays held until the next grant.
  - Watchdog cleared; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On sqrt_valid_out=1: latch sqrt_result into resp_data, resp_err=0, go to RESP.
  - If watchdog reaches TIMEOUT_CYCLES-1 with no valid_out: resp_data=0, resp_err=1, go to RESP.
  - If valid_out and timeout occur in the same cycle, valid_out wins.
- RESP:
  - resp_valid[owner]=1, registered; resp_data and resp_err held stable until resp_ready[owner]=1.
  - On handshake: rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
  - resp_ready on non-owner lanes is ignored.
- Latency: acceptance at edge T gives sqrt_valid_in high in cycle T+1. A sqrt result arriving in cycle T+1+L gives resp_valid high from cycle T+2+L.
- Throughput: one request per (L+3) cycles minimum; back-to-back requests are not overlapped.
- spurious_flag: set when sqrt_valid_out=1 in IDLE, ISSUE or RESP, including a late result after timeout or reset. The pulse is otherwise ignored; the flag clears only on reset.
- No request is lost: lanes hold req_valid and req_radicand until req_ready. A lane re-requesting while its own response is pending is simply not granted until the FSM returns to IDLE.
- Reset mid-operation abandons the in-flight request; no response is issued for it.

Test Plan:
1. Lane 0 only, radicand 4194304, bit-accurate sqrt model with L=12 -> one req_ready[0] pulse, sqrt_valid_in one cycle later, resp_valid[0] at accept+14, resp_data[11:0]=2048, resp_err=0.
2. All four lanes valid in the same cycle after reset, radicands 4194304/2359296/262144/11 -> served in order 0,1,2,3; results 2048, 1536, 512, 3; each returned only on the matching resp_valid bit.
3. Lanes 0 and 2 held valid continuously for 6 grants, resp_ready tied high -> grant order 0,2,0,2,0,2; lanes 1 and 3 never ready.
4. Sqrt model never asserts valid_out -> resp_valid[owner] rises TIMEOUT_CYCLES cycles after entering WAIT with resp_err=1 and resp_data=0. Injecting valid_out 5 cycles later sets spurious_flag=1.
5. resp_ready[owner] held low 5 cycles in RESP while another lane requests -> resp_valid/resp_data stable, no req_ready asserted; grant to the next lane occurs the cycle after the handshake.
6. Assert rst_n=0 for 2 cycles during WAIT, then release -> all outputs 0, state IDLE. The late sqrt_valid_out sets spurious_flag; no resp_valid is produced for the abandoned request.

Source files
------------

// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter: shares one non-restoring square-root unit between
// several layernorm lanes. A round-robin arbiter picks one lane at a time.
// The FSM issues the radicand and waits for the result, with a watchdog
// that aborts the wait. It then returns the result to the owning lane over
// a valid/ready response channel.
module sqrt_share_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_IN_WIDTH   = 24,
    parameter int FINAL_OUT_WIDTH = 24,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int CNT_WIDTH       = 7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_radicand,
    output logic [NUM_REQ-1:0]                 resp_valid,
    input  logic [NUM_REQ-1:0]                 resp_ready,
    output logic [FINAL_OUT_WIDTH-1:0]         resp_data,
    output logic                               resp_err,
    output logic                               sqrt_valid_in,
    output logic [DATA_IN_WIDTH-1:0]           sqrt_radicand,
    input  logic                               sqrt_valid_out,
    input  logic [FINAL_OUT_WIDTH-1:0]         sqrt_result,
    output logic                               busy,
    output logic                               spurious_flag
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0]     NUM_REQ_S = SUM_W'(NUM_REQ);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           rr_ptr;
    logic [IDX_W-1:0]           owner;
    logic [CNT_WIDTH-1:0]       watchdog;

    logic                       grant_found;
    logic [IDX_W-1:0]           grant_idx;
    logic [SUM_W-1:0]           cand_sum;
    logic [DATA_IN_WIDTH-1:0]   lane_radicand;
    logic [NUM_REQ-1:0]         owner_onehot;
    logic                       owner_ready;

    // Round-robin search: first requesting lane at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = SUM_W'(rr_ptr) + SUM_W'(k);
            if (cand_sum >= NUM_REQ_S) begin
                cand_sum = cand_sum - NUM_REQ_S;
            end
            if (!grant_found && req_valid[cand_sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    // Select the granted lane's radicand and decode the current owner.
    always_comb begin
        lane_radicand = '0;
        owner_onehot  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                lane_radicand = req_radicand[k*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            end
            owner_onehot[k] = (owner == IDX_W'(k));
        end
    end

    // Accept is offered only from IDLE, to the single granted lane, never in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign owner_ready = |(resp_ready & owner_onehot);
    assign busy        = (state != IDLE);

    // Main FSM: grant, issue one pulse, wait with watchdog, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            watchdog      <= '0;
            resp_valid    <= '0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            sqrt_valid_in <= 1'b0;
            sqrt_radicand <= '0;
            spurious_flag <= 1'b0;
        end else begin
            sqrt_valid_in <= 1'b0;
            if (sqrt_valid_out && (state != WAIT)) begin
                spurious_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        sqrt_radicand <= lane_radicand;
                        owner         <= grant_idx;
                        sqrt_valid_in <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    if (sqrt_valid_out) begin
                        resp_data  <= sqrt_result;
                        resp_err   <= 1'b0;
                        resp_valid <= owner_onehot;
                        state      <= RESP;
                    end else if (watchdog == WDOG_LAST) begin
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= owner_onehot;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        resp_valid <= '0;
                        rr_ptr     <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// tb_sqrt_share_arbiter: drives randomized and directed lane requests into
// the shared sqrt arbiter. A behavioural sqrt unit (integer floor root with
// fixed latency) sits behind the arbiter. A scoreboard predicts the grant
// order, results, error flags and response latency, and a monitor compares
// them whenever the DUT grants or responds.
module tb_sqrt_share_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 24;
    localparam int OW  = 24;
    localparam int TO  = 64;
    localparam int CW  = 7;
    localparam int LAT = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_radicand;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [OW-1:0]     resp_data;
    logic              resp_err;
    logic              sqrt_valid_in;
    logic [DW-1:0]     sqrt_radicand;
    logic              sqrt_valid_out;
    logic [OW-1:0]     sqrt_result;
    logic              busy;
    logic              spurious_flag;

    sqrt_share_arbiter #(
        .NUM_REQ(NR), .DATA_IN_WIDTH(DW), .FINAL_OUT_WIDTH(OW),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_radicand(req_radicand),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .sqrt_valid_in(sqrt_valid_in), .sqrt_radicand(sqrt_radicand),
        .sqrt_valid_out(sqrt_valid_out), .sqrt_result(sqrt_result),
        .busy(busy), .spurious_flag(spurious_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          lane;
        logic [23:0] data;
        logic        err;
        int          acc;
        bit          seen;
    } exp_t;

    typedef struct {
        int          due;
        logic [23:0] val;
    } pend_t;

    int          n_checks = 0;
    int          n_bad    = 0;
    exp_t        sb[$];
    pend_t       pend[$];
    logic [23:0] lane_q[NR][$];
    int          out_lane[$];
    logic [23:0] out_data[$];
    bit          model_busy = 0;
    int          model_ptr = 0;
    int          exp_issue_cyc = -1;
    logic [23:0] exp_issue_rad = '0;
    int          grant_cyc_lane[NR];
    int          hs_cyc_lane[NR];
    int          resp_cycles = 0;
    bit          sqrt_drop = 0;
    int          inject_cyc = -1;
    bit          rand_ready = 0;
    logic [NR-1:0] resp_ready_cfg = '1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        n_bad++;
        $display("[TB] FAIL %s: actual=no event required=event within bound at t=%0t", name, $time);
    endtask

    function automatic logic [23:0] isqrt(input logic [23:0] x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= longint'(x)) r++;
        return 24'(r);
    endfunction

    function automatic logic [NR-1:0] onehot(input int lane);
        logic [NR-1:0] v = '0;
        if (lane >= 0 && lane < NR) v[lane] = 1'b1;
        return v;
    endfunction

    function automatic int expGrant(input int ptr, input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input int lane, input logic [23:0] rad);
        lane_q[lane].push_back(rad);
    endtask

    task automatic waitDrain(input int budget, input string tag);
        int  n = 0;
        bit  done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (sb.size() == 0) && !model_busy && (req_valid == '0);
            for (int i = 0; i < NR; i++) if (lane_q[i].size() != 0) done = 0;
        end
        if (!done) failNow(tag);
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"},     64'(req_ready), 64'(0));
        checkOutput({tag, "_resp_valid"},    64'(resp_valid), 64'(0));
        checkOutput({tag, "_resp_data"},     64'(resp_data), 64'(0));
        checkOutput({tag, "_resp_err"},      64'(resp_err), 64'(0));
        checkOutput({tag, "_sqrt_valid_in"}, 64'(sqrt_valid_in), 64'(0));
        checkOutput({tag, "_sqrt_radicand"}, 64'(sqrt_radicand), 64'(0));
        checkOutput({tag, "_busy"},          64'(busy), 64'(0));
        checkOutput({tag, "_spurious"},      64'(spurious_flag), 64'(0));
    endtask

    task automatic doReset(input string tag);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs(tag);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Lane driver: holds each lane's request until it is accepted.
    initial begin
        logic [NR-1:0] acc_v;
        req_valid    = '0;
        req_radicand = '0;
        resp_ready   = '1;
        forever begin
            @(posedge clk);
            acc_v = req_ready & req_valid;
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc_v[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
                req_valid[i] = (lane_q[i].size() > 0);
                req_radicand[i*DW +: DW] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
            end
            resp_ready = rand_ready ? NR'($urandom) : resp_ready_cfg;
        end
    end

    // Behavioural sqrt unit: floor root, LAT cycles after valid_in; survives DUT reset.
    initial begin
        sqrt_valid_out = 1'b0;
        sqrt_result    = '0;
        forever begin
            @(posedge clk);
            #1;
            sqrt_valid_out = 1'b0;
            sqrt_result    = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                sqrt_valid_out = 1'b1;
                sqrt_result    = pend[0].val;
                void'(pend.pop_front());
            end else if (inject_cyc == cyc) begin
                sqrt_valid_out = 1'b1;
                sqrt_result    = 24'h00ABCD;
            end
            if (sqrt_valid_in && !sqrt_drop) begin
                pend.push_back('{due: cyc + LAT, val: isqrt(sqrt_radicand)});
            end
        end
    end

    // Monitor: predicts grants, issue pulses and responses, pops the scoreboard on handshake.
    always @(negedge clk) begin : monitor
        exp_t h;
        int   g;
        if (!rst_n) begin
            sb.delete();
            model_busy    = 0;
            model_ptr     = 0;
            exp_issue_cyc = -1;
        end else begin
            checkOutput("busy", 64'(busy), 64'(model_busy));
            if (sqrt_valid_in || cyc == exp_issue_cyc) begin
                checkOutput("sqrt_valid_in", 64'(sqrt_valid_in), 64'(cyc == exp_issue_cyc));
                if (cyc == exp_issue_cyc) checkOutput("sqrt_radicand", 64'(sqrt_radicand), 64'(exp_issue_rad));
            end
            if (req_ready != '0 || (!model_busy && req_valid != '0)) begin
                g = model_busy ? -1 : expGrant(model_ptr, req_valid);
                checkOutput("req_ready", 64'(req_ready), 64'(onehot(g)));
                if (g >= 0) begin
                    model_busy = 1;
                    h.lane = g;
                    h.err  = sqrt_drop;
                    h.data = sqrt_drop ? 24'd0 : isqrt(lane_q[g][0]);
                    h.acc  = cyc;
                    h.seen = 0;
                    sb.push_back(h);
                    exp_issue_cyc     = cyc + 1;
                    exp_issue_rad     = lane_q[g][0];
                    grant_cyc_lane[g] = cyc;
                end
            end
            if (resp_valid != '0) begin
                resp_cycles++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_resp", 64'(resp_valid), 64'(0));
                end else begin
                    h = sb[0];
                    checkOutput("resp_valid", 64'(resp_valid), 64'(onehot(h.lane)));
                    checkOutput("resp_data", 64'(resp_data), 64'(h.data));
                    checkOutput("resp_err", 64'(resp_err), 64'(h.err));
                    if (!h.seen) begin
                        checkOutput("resp_latency", 64'(cyc - h.acc), h.err ? 64'(TO + 2) : 64'(LAT + 2));
                        sb[0].seen = 1;
                    end
                    if (resp_ready[h.lane]) begin
                        hs_cyc_lane[h.lane] = cyc;
                        out_lane.push_back(h.lane);
                        out_data.push_back(resp_data);
                        void'(sb.pop_front());
                        model_busy = 0;
                        model_ptr  = (h.lane + 1) % NR;
                    end
                end
            end else if (sb.size() > 0 && sb[0].seen) begin
                checkOutput("resp_held", 64'(resp_valid), 64'(onehot(sb[0].lane)));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: actual=still running required=finished");
        $fatal(1);
    end

    initial begin
        int t2_rad[4] = '{4194304, 2359296, 262144, 11};
        int t2_exp[4] = '{2048, 1536, 512, 3};
        int n, r, acc, rc0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Single lane, nominal latency and result.
        out_lane.delete(); out_data.delete();
        applyStimulus(0, 24'd4194304);
        waitDrain(200, "t1_drain");
        checkOutput("t1_count", 64'(out_lane.size()), 64'(1));
        if (out_data.size() > 0) checkOutput("t1_data", 64'(out_data[0][11:0]), 64'(2048));

        // Four lanes at once right after reset: served 0,1,2,3.
        doReset("t2_rst");
        out_lane.delete(); out_data.delete();
        for (int i = 0; i < 4; i++) applyStimulus(i, 24'(t2_rad[i]));
        waitDrain(300, "t2_drain");
        checkOutput("t2_count", 64'(out_lane.size()), 64'(4));
        for (int i = 0; i < 4 && i < out_lane.size(); i++) begin
            checkOutput("t2_order", 64'(out_lane[i]), 64'(i));
            checkOutput("t2_data", 64'(out_data[i]), 64'(t2_exp[i]));
        end

        // Lanes 0 and 2 continuously requesting: alternate.
        out_lane.delete(); out_data.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 24'($urandom));
            applyStimulus(2, 24'($urandom));
        end
        waitDrain(400, "t3_drain");
        checkOutput("t3_count", 64'(out_lane.size()), 64'(6));
        for (int i = 0; i < 6 && i < out_lane.size(); i++) begin
            checkOutput("t3_order", 64'(out_lane[i]), (i % 2 == 0) ? 64'(0) : 64'(2));
        end

        // Owner stalls the response while another lane waits.
        resp_ready_cfg = 4'b1101;
        applyStimulus(1, 24'd262144);
        n = 0;
        while (resp_valid[1] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) failNow("t5_wait_resp");
        applyStimulus(3, 24'd2359296);
        repeat (5) begin
            @(negedge clk);
            checkOutput("t5_no_ready", 64'(req_ready), 64'(0));
            checkOutput("t5_valid_held", 64'(resp_valid), 64'(4'b0010));
            checkOutput("t5_data_held", 64'(resp_data), 64'(512));
        end
        resp_ready_cfg = '1;
        waitDrain(200, "t5_drain");
        checkOutput("t5_next_grant", 64'(grant_cyc_lane[3] - hs_cyc_lane[1]), 64'(1));

        // Randomized traffic with random response back-pressure, plus boundary radicands.
        rand_ready = 1;
        applyStimulus(0, 24'd0);
        applyStimulus(3, 24'hFFFFFF);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, NR - 1)), 24'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        waitDrain(4000, "rand_drain");
        rand_ready = 0;
        @(negedge clk);
        checkOutput("rand_spurious", 64'(spurious_flag), 64'(0));

        // Sqrt unit never answers: timeout response, then a late pulse is spurious.
        sqrt_drop = 1;
        resp_ready_cfg = '0;
        repeat (2) @(negedge clk);
        applyStimulus(1, 24'd4194304);
        n = 0;
        while (resp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) failNow("t4_wait_resp");
        r = cyc;
        checkOutput("t4_err", 64'(resp_err), 64'(1));
        checkOutput("t4_data", 64'(resp_data), 64'(0));
        checkOutput("t4_spur_before", 64'(spurious_flag), 64'(0));
        inject_cyc = r + 5;
        n = 0;
        while (cyc < r + 6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_spur_after", 64'(spurious_flag), 64'(1));
        checkOutput("t4_valid_held", 64'(resp_valid), 64'(onehot(1)));
        resp_ready_cfg = '1;
        waitDrain(100, "t4_drain");
        sqrt_drop = 0;

        // Reset during WAIT abandons the request; the late result is spurious.
        doReset("t6_pre");
        applyStimulus(2, 24'd11);
        n = 0;
        while (req_ready[2] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) failNow("t6_wait_grant");
        acc = cyc;
        while (cyc < acc + 5) @(negedge clk);
        checkOutput("t6_busy_wait", 64'(busy), 64'(1));
        doReset("t6_mid");
        rc0 = resp_cycles;
        while (cyc < acc + 16) @(negedge clk);
        checkOutput("t6_spurious", 64'(spurious_flag), 64'(1));
        checkOutput("t6_no_resp", 64'(resp_cycles - rc0), 64'(0));
        checkOutput("t6_idle", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
